// File: rtl/chan_req_tx.sv
// Port-side channel transmitter: buffers packets, requests the shared channel and streams on grant.
// Optional request watchdog enabled by defining CHAN_REQ_TX_TIMEOUT_EN.
module chan_req_tx #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned BACKOFF_CYC = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_vld,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_eop,
  output logic                  o_wr_rdy,
  output logic                  o_chan_req,
  input  logic                  i_chan_resp,
  input  logic                  i_chan_nresp,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_vld,
  output logic                  o_data_last,
  output logic                  o_timeout
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StSend, StRel, StBackoff} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic [BW-1:0]         bo_cnt_q, bo_cnt_d;
  logic                  chan_req_q, chan_req_d, end_q, end_d;
  logic                  data_vld_q, data_vld_d, data_last_q, data_last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DATA_WIDTH:0]   rd_word;
  logic                  wr_en, rd_en, rd_eop, wr_eop, timeout_evt;

  assign o_wr_rdy = (cnt_q != CW'(DEPTH));
  assign wr_en    = i_wr_vld & o_wr_rdy;
  assign wr_eop   = wr_en & i_wr_eop;
  assign rd_word  = mem_q[rd_ptr_q];
  assign rd_en    = (state_q == StSend) && (cnt_q != '0);
  assign rd_eop   = rd_en & rd_word[DATA_WIDTH];

`ifdef CHAN_REQ_TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q;
  logic          req_wait;

  assign req_wait    = (state_q == StReq) && !i_chan_resp && !i_chan_nresp;
  assign timeout_evt = req_wait && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign to_cnt_d    = (req_wait && !timeout_evt) ? to_cnt_q + TW'(1) : '0;
  assign o_timeout   = timeout_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_evt;
    end
  end
`else
  assign timeout_evt = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {i_wr_eop, i_wr_data};
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Packet count saturates rather than wrapping; simultaneous +1/-1 cancels.
    pkt_cnt_d = pkt_cnt_q;
    if (wr_eop && !rd_eop && pkt_cnt_q != CW'(DEPTH)) pkt_cnt_d = pkt_cnt_q + CW'(1);
    else if (rd_eop && !wr_eop && pkt_cnt_q != '0)     pkt_cnt_d = pkt_cnt_q - CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    bo_cnt_d = bo_cnt_q;
    case (state_q)
      StIdle: if (pkt_cnt_q != '0) state_d = StReq;
      StReq: begin
        if (i_chan_resp) begin
          state_d = StSend;
        end else if (i_chan_nresp || timeout_evt) begin
          state_d  = StBackoff;
          bo_cnt_d = '0;
        end
      end
      StSend: if (rd_eop) state_d = StRel;
      StRel:  state_d = StIdle;
      StBackoff: begin
        if (bo_cnt_q == BW'(BACKOFF_CYC - 1)) begin
          bo_cnt_d = '0;
          state_d  = (pkt_cnt_q != '0) ? StReq : StIdle;
        end else begin
          bo_cnt_d = bo_cnt_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs follow the state one edge late, matching the protocol's request/release timing.
    chan_req_d  = (state_q == StReq) || (state_q == StSend);
    end_d       = (state_q == StRel);
    data_vld_d  = rd_en;
    data_last_d = rd_eop;
    data_d      = rd_en ? rd_word[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pkt_cnt_q   <= '0;
      bo_cnt_q    <= '0;
      chan_req_q  <= 1'b0;
      end_q       <= 1'b0;
      data_vld_q  <= 1'b0;
      data_last_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      bo_cnt_q    <= bo_cnt_d;
      chan_req_q  <= chan_req_d;
      end_q       <= end_d;
      data_vld_q  <= data_vld_d;
      data_last_q <= data_last_d;
      data_q      <= data_d;
    end
  end

  assign o_chan_req  = chan_req_q;
  assign o_end       = end_q;
  assign o_data      = data_q;
  assign o_data_vld  = data_vld_q;
  assign o_data_last = data_last_q;

endmodule

// File: tb/tb_chan_req_tx.sv
// Directed self-checking bench for chan_req_tx (DEPTH=32, BACKOFF_CYC=4).
module tb_chan_req_tx;
  localparam int DW = 64;
  localparam int DEP = 32;
  localparam int BO = 4;
`ifdef CHAN_REQ_TX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_wr_vld = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_wr_eop = 1'b0;
  logic          o_wr_rdy;
  logic          o_chan_req;
  logic          i_chan_resp = 1'b0;
  logic          i_chan_nresp = 1'b0;
  logic          o_end;
  logic [DW-1:0] o_data;
  logic          o_data_vld;
  logic          o_data_last;
  logic          o_timeout;

  int total = 0;
  int bad = 0;

  chan_req_tx #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .BACKOFF_CYC(BO),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_vld    (i_wr_vld),
    .i_wr_data   (i_wr_data),
    .i_wr_eop    (i_wr_eop),
    .o_wr_rdy    (o_wr_rdy),
    .o_chan_req  (o_chan_req),
    .i_chan_resp (i_chan_resp),
    .i_chan_nresp(i_chan_nresp),
    .o_end       (o_end),
    .o_data      (o_data),
    .o_data_vld  (o_data_vld),
    .o_data_last (o_data_last),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic e);
    i_wr_vld  = 1'b1;
    i_wr_data = d;
    i_wr_eop  = e;
    step();
    i_wr_vld  = 1'b0;
    i_wr_eop  = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!o_chan_req && n < 40) begin
      step();
      n++;
    end
    ok = o_chan_req;
  endtask

  task automatic test_reset();
    #12 i_rst = 1'b1;
    #1;
    total++;
    if ({o_chan_req, o_end, o_data_vld, o_data_last, o_timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00000",
                      {o_chan_req, o_end, o_data_vld, o_data_last, o_timeout});
    end
    total++;
    if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
    total++;
    if (o_wr_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", o_wr_rdy); end
    step(); step();
    i_rst = 1'b0;
    repeat (3) step();
    total++;
    if (o_chan_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", o_chan_req); end
  endtask

  task automatic test_three_word();
    put(64'hA, 1'b0); put(64'hB, 1'b0); put(64'hC, 1'b1);
    total++;
    if (o_chan_req !== 1'b0) begin bad++; $display("FAIL lat_n got=%b exp=0", o_chan_req); end
    step();
    total++;
    if (o_chan_req !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b exp=0", o_chan_req); end
    step();
    total++;
    if (o_chan_req !== 1'b1) begin bad++; $display("FAIL lat_n2 got=%b exp=1", o_chan_req); end
    step();
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    total++;
    if ({o_chan_req, o_data_vld} !== 2'b10) begin
      bad++; $display("FAIL grant_edge got=%b exp=10", {o_chan_req, o_data_vld});
    end
    step();
    total++;
    if ({o_data_vld, o_data_last, o_data} !== {2'b10, 64'hA}) begin
      bad++; $display("FAIL word_a got=%b%b/%h exp=10/a", o_data_vld, o_data_last, o_data);
    end
    step();
    total++;
    if ({o_data_vld, o_data_last, o_data} !== {2'b10, 64'hB}) begin
      bad++; $display("FAIL word_b got=%b%b/%h exp=10/b", o_data_vld, o_data_last, o_data);
    end
    step();
    total++;
    if ({o_data_vld, o_data_last, o_end, o_chan_req, o_data} !== {4'b1101, 64'hC}) begin
      bad++; $display("FAIL word_c got=%b%b%b%b/%h exp=1101/c",
                      o_data_vld, o_data_last, o_end, o_chan_req, o_data);
    end
    step();
    total++;
    if ({o_end, o_chan_req, o_data_vld} !== 3'b100) begin
      bad++; $display("FAIL release got=%b exp=100", {o_end, o_chan_req, o_data_vld});
    end
    step();
    total++;
    if (o_end !== 1'b0) begin bad++; $display("FAIL end_pulse got=%b exp=0", o_end); end
  endtask

  task automatic test_refusal();
    bit ok;
    put(64'h55, 1'b1);
    wait_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL nr_req got=0 exp=1"); end
    i_chan_nresp = 1'b1;
    step();
    i_chan_nresp = 1'b0;
    for (int i = 1; i <= BO; i++) begin
      step();
      total++;
      if (o_chan_req !== 1'b0) begin bad++; $display("FAIL backoff_%0d got=1 exp=0", i); end
    end
    step();
    total++;
    if (o_chan_req !== 1'b1) begin bad++; $display("FAIL rereq got=0 exp=1"); end
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({o_data_vld, o_data_last, o_data} !== {2'b11, 64'h55}) begin
      bad++; $display("FAIL nr_data got=%b%b/%h exp=11/55", o_data_vld, o_data_last, o_data);
    end
    step();
    total++;
    if ({o_end, o_chan_req} !== 2'b10) begin
      bad++; $display("FAIL nr_end got=%b exp=10", {o_end, o_chan_req});
    end
  endtask

  task automatic test_resp_wins();
    bit ok;
    put(64'h77, 1'b1);
    wait_req(ok);
    i_chan_resp  = 1'b1;
    i_chan_nresp = 1'b1;
    step();
    i_chan_resp  = 1'b0;
    i_chan_nresp = 1'b0;
    step();
    total++;
    if ({ok, o_chan_req, o_data_vld, o_data_last, o_data} !== {4'b1111, 64'h77}) begin
      bad++; $display("FAIL resp_wins got=%b%b%b%b/%h exp=1111/77",
                      ok, o_chan_req, o_data_vld, o_data_last, o_data);
    end
    step();
    total++;
    if (o_end !== 1'b1) begin bad++; $display("FAIL rw_end got=%b exp=1", o_end); end
  endtask

  task automatic test_full();
    bit ok;
    for (int w = 0; w < DEP; w++) begin
      if (w == DEP - 1) begin
        total++;
        if (o_wr_rdy !== 1'b1) begin bad++; $display("FAIL rdy_31 got=0 exp=1"); end
      end
      put(64'h100 + 64'(w), (w == 15) || (w == 31));
    end
    total++;
    if (o_wr_rdy !== 1'b0) begin bad++; $display("FAIL rdy_full got=1 exp=0"); end
    put(64'hBAD, 1'b1);  // dropped: FIFO full
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({o_data_vld, o_wr_rdy, o_data} !== {2'b11, 64'h100}) begin
      bad++; $display("FAIL full_w0 got=%b%b/%h exp=11/100", o_data_vld, o_wr_rdy, o_data);
    end
    put(64'hD00D, 1'b1);  // write and read in the same cycle
    total++;
    if ({o_data_vld, o_data} !== {1'b1, 64'h101}) begin
      bad++; $display("FAIL full_w1 got=%b/%h exp=1/101", o_data_vld, o_data);
    end
    for (int w = 2; w < 16; w++) begin
      step();
      total++;
      if ({o_data_vld, o_data_last, o_data} !== {1'b1, w == 15, 64'h100 + 64'(w)}) begin
        bad++; $display("FAIL p1_w%0d got=%b%b/%h exp=1%b/%h", w, o_data_vld, o_data_last,
                        o_data, w == 15, 64'h100 + 64'(w));
      end
    end
    step();
    total++;
    if ({o_end, o_chan_req} !== 2'b10) begin
      bad++; $display("FAIL p1_end got=%b exp=10", {o_end, o_chan_req});
    end
    wait_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL p2_req got=0 exp=1"); end
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    for (int w = 0; w < 16; w++) begin
      step();
      total++;
      if ({o_data_vld, o_data_last, o_data} !== {1'b1, w == 15, 64'h110 + 64'(w)}) begin
        bad++; $display("FAIL p2_w%0d got=%b%b/%h exp=1%b/%h", w, o_data_vld, o_data_last,
                        o_data, w == 15, 64'h110 + 64'(w));
      end
    end
    step();
    total++;
    if (o_end !== 1'b1) begin bad++; $display("FAIL p2_end got=%b exp=1", o_end); end
    wait_req(ok);
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({ok, o_data_vld, o_data_last, o_data} !== {3'b111, 64'hD00D}) begin
      bad++; $display("FAIL p3 got=%b%b%b/%h exp=111/d00d", ok, o_data_vld, o_data_last, o_data);
    end
    step();
    total++;
    if (o_end !== 1'b1) begin bad++; $display("FAIL p3_end got=%b exp=1", o_end); end
  endtask

  task automatic test_watchdog();
    bit ok;
    int err = 0;
    put(64'h99, 1'b1);
    wait_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wd_req got=0 exp=1"); end
`ifdef CHAN_REQ_TX_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      step();
      if (o_timeout !== 1'b0) err++;
    end
    step();
    total++;
    if ({err == 0, o_timeout, o_chan_req} !== 3'b111) begin
      bad++; $display("FAIL wd_pulse got=%0d%b%b exp=111", err == 0, o_timeout, o_chan_req);
    end
    for (int i = 1; i <= BO; i++) begin
      step();
      total++;
      if ({o_timeout, o_chan_req} !== 2'b00) begin
        bad++; $display("FAIL wd_bo_%0d got=%b exp=00", i, {o_timeout, o_chan_req});
      end
    end
    step();
    total++;
    if (o_chan_req !== 1'b1) begin bad++; $display("FAIL wd_rereq got=0 exp=1"); end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      if (o_chan_req !== 1'b1 || o_timeout !== 1'b0) err++;
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL req_hold got=%0d_bad_cycles exp=0", err); end
`endif
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({o_data_vld, o_data_last, o_data} !== {2'b11, 64'h99}) begin
      bad++; $display("FAIL wd_data got=%b%b/%h exp=11/99", o_data_vld, o_data_last, o_data);
    end
    step();
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    int err = 0;
    put(64'h1, 1'b0); put(64'h2, 1'b0); put(64'h3, 1'b1);
    wait_req(ok);
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({ok, o_data_vld, o_data} !== {2'b11, 64'h1}) begin
      bad++; $display("FAIL ms_first got=%b%b/%h exp=11/1", ok, o_data_vld, o_data);
    end
    #3 i_rst = 1'b1;
    #1;
    total++;
    if ({o_chan_req, o_end, o_data_vld, o_data_last, o_wr_rdy} !== 5'b00001) begin
      bad++; $display("FAIL ms_reset got=%b exp=00001",
                      {o_chan_req, o_end, o_data_vld, o_data_last, o_wr_rdy});
    end
    step(); step();
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_chan_req || o_end || o_data_vld) err++;
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL ms_quiet got=%0d_bad_cycles exp=0", err); end
    put(64'h42, 1'b1);
    wait_req(ok);
    i_chan_resp = 1'b1;
    step();
    i_chan_resp = 1'b0;
    step();
    total++;
    if ({ok, o_data_vld, o_data_last, o_data} !== {3'b111, 64'h42}) begin
      bad++; $display("FAIL ms_after got=%b%b%b/%h exp=111/42", ok, o_data_vld, o_data_last, o_data);
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_refusal();
    test_resp_wins();
    test_full();
    test_watchdog();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
